// File: rtl/rps_match.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rps_match                                                     |
// | Purpose  : Best-of-N rock-paper-scissors match controller with two       |
// |            valid/ready move inputs, score keeping and match verdict.     |
// |            Optional tie-limit draw rule enabled by RPS_TIE_LIMIT_EN.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rps_match #(
    parameter int WIN_TARGET = 3,
    parameter int SCORE_W    = 4,
    parameter int TIE_LIMIT  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               p0_valid,
    input  logic [1:0]         p0_move,
    output logic               p0_ready,
    input  logic               p1_valid,
    input  logic [1:0]         p1_move,
    output logic               p1_ready,
    output logic               round_valid,
    output logic [1:0]         round_result,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic               match_done,
    output logic [1:0]         match_winner
);

    localparam logic [1:0] c_RES_P0  = 2'd0;
    localparam logic [1:0] c_RES_P1  = 2'd1;
    localparam logic [1:0] c_RES_TIE = 2'd2;
    localparam logic [1:0] c_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_held0, r_held1, w_held0_nxt, w_held1_nxt;
    logic [1:0]         r_move0, r_move1, w_move0_nxt, w_move1_nxt;
    logic [SCORE_W-1:0] r_score0, r_score1, w_score0_nxt, w_score1_nxt;
    logic [1:0]         r_winner, w_winner_nxt;
    logic               r_ready0, r_ready1, w_ready0_nxt, w_ready1_nxt;
    logic [2:0]         w_diff;
    logic [1:0]         w_result;

`ifdef RPS_TIE_LIMIT_EN
    localparam int c_TIE_W = $clog2(TIE_LIMIT + 1);
    logic [c_TIE_W-1:0] r_tie_cnt, w_tie_cnt_nxt;
`endif

    // Out-of-range parameters elaborate this empty marker scope only.
    generate
        if (WIN_TARGET < 1 || WIN_TARGET > (2**SCORE_W) - 1 || TIE_LIMIT < 1) begin : g_param_range_bad
        end
    endgenerate

    // Round verdict from the held moves; an illegal move loses to any legal one.
    always_comb begin
        w_diff = 3'd3 + {1'b0, r_move0} - {1'b0, r_move1};
        if (w_diff >= 3'd3) begin
            w_diff = w_diff - 3'd3;
        end
        if (r_move0 == c_ILLEGAL && r_move1 == c_ILLEGAL) begin
            w_result = c_RES_TIE;
        end else if (r_move0 == c_ILLEGAL) begin
            w_result = c_RES_P1;
        end else if (r_move1 == c_ILLEGAL) begin
            w_result = c_RES_P0;
        end else begin
            case (w_diff)
                3'd0:    w_result = c_RES_TIE;
                3'd1:    w_result = c_RES_P0;
                default: w_result = c_RES_P1;
            endcase
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_held0_nxt  = r_held0;
        w_held1_nxt  = r_held1;
        w_move0_nxt  = r_move0;
        w_move1_nxt  = r_move1;
        w_score0_nxt = r_score0;
        w_score1_nxt = r_score1;
        w_winner_nxt = r_winner;
`ifdef RPS_TIE_LIMIT_EN
        w_tie_cnt_nxt = r_tie_cnt;
`endif
        case (r_state)
            COLLECT: begin
                if (p0_valid && r_ready0) begin
                    w_held0_nxt = 1'b1;
                    w_move0_nxt = p0_move;
                end
                if (p1_valid && r_ready1) begin
                    w_held1_nxt = 1'b1;
                    w_move1_nxt = p1_move;
                end
                if (w_held0_nxt && w_held1_nxt) begin
                    w_state_nxt = RESOLVE;
                end
            end
            RESOLVE: begin
                w_state_nxt = COLLECT;
                w_held0_nxt = 1'b0;
                w_held1_nxt = 1'b0;
`ifdef RPS_TIE_LIMIT_EN
                w_tie_cnt_nxt = '0;
`endif
                case (w_result)
                    c_RES_P0: begin
                        if (r_score0 != {SCORE_W{1'b1}}) begin
                            w_score0_nxt = r_score0 + 1'b1;
                        end
                        if (w_score0_nxt == SCORE_W'(WIN_TARGET)) begin
                            w_state_nxt  = DONE;
                            w_winner_nxt = c_RES_P0;
                        end
                    end
                    c_RES_P1: begin
                        if (r_score1 != {SCORE_W{1'b1}}) begin
                            w_score1_nxt = r_score1 + 1'b1;
                        end
                        if (w_score1_nxt == SCORE_W'(WIN_TARGET)) begin
                            w_state_nxt  = DONE;
                            w_winner_nxt = c_RES_P1;
                        end
                    end
                    default: begin
`ifdef RPS_TIE_LIMIT_EN
                        w_tie_cnt_nxt = r_tie_cnt + 1'b1;
                        if (w_tie_cnt_nxt == c_TIE_W'(TIE_LIMIT)) begin
                            w_state_nxt  = DONE;
                            w_winner_nxt = c_RES_TIE;
                        end
`else
                        w_state_nxt = COLLECT;
`endif
                    end
                endcase
            end
            default: ;
        endcase

        // start overrides everything, including a same-cycle handshake or score update.
        if (start) begin
            w_state_nxt  = COLLECT;
            w_held0_nxt  = 1'b0;
            w_held1_nxt  = 1'b0;
            w_score0_nxt = '0;
            w_score1_nxt = '0;
`ifdef RPS_TIE_LIMIT_EN
            w_tie_cnt_nxt = '0;
`endif
        end

        w_ready0_nxt = (w_state_nxt == COLLECT) && !w_held0_nxt;
        w_ready1_nxt = (w_state_nxt == COLLECT) && !w_held1_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_held0  <= 1'b0;
            r_held1  <= 1'b0;
            r_move0  <= 2'd0;
            r_move1  <= 2'd0;
            r_score0 <= '0;
            r_score1 <= '0;
            r_winner <= 2'd0;
            r_ready0 <= 1'b0;
            r_ready1 <= 1'b0;
`ifdef RPS_TIE_LIMIT_EN
            r_tie_cnt <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_held0  <= w_held0_nxt;
            r_held1  <= w_held1_nxt;
            r_move0  <= w_move0_nxt;
            r_move1  <= w_move1_nxt;
            r_score0 <= w_score0_nxt;
            r_score1 <= w_score1_nxt;
            r_winner <= w_winner_nxt;
            r_ready0 <= w_ready0_nxt;
            r_ready1 <= w_ready1_nxt;
`ifdef RPS_TIE_LIMIT_EN
            r_tie_cnt <= w_tie_cnt_nxt;
`endif
        end
    end

    assign p0_ready     = r_ready0;
    assign p1_ready     = r_ready1;
    assign round_valid  = (r_state == RESOLVE);
    assign round_result = round_valid ? w_result : 2'd0;
    assign score0       = r_score0;
    assign score1       = r_score1;
    assign match_done   = (r_state == DONE);
    assign match_winner = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_rps_match.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rps_match                                                  |
// | Purpose  : Randomised self-checking bench for rps_match against a        |
// |            match-level reference model.                                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_rps_match;

    localparam int WIN_TARGET = 3;
    localparam int SCORE_W    = 4;
    localparam int TIE_LIMIT  = 5;
    localparam int SCORE_MAX  = (2**SCORE_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               p0_valid, p1_valid;
    logic [1:0]         p0_move, p1_move;
    logic               p0_ready, p1_ready;
    logic               round_valid;
    logic [1:0]         round_result;
    logic [SCORE_W-1:0] score0, score1;
    logic               match_done;
    logic [1:0]         match_winner;

    int n_tests = 0;
    int n_fail  = 0;

    int m_s0, m_s1, m_ties, m_winner;
    bit m_done;

    rps_match #(
        .WIN_TARGET (WIN_TARGET),
        .SCORE_W    (SCORE_W),
        .TIE_LIMIT  (TIE_LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .p0_valid     (p0_valid),
        .p0_move      (p0_move),
        .p0_ready     (p0_ready),
        .p1_valid     (p1_valid),
        .p1_move      (p1_move),
        .p1_ready     (p1_ready),
        .round_valid  (round_valid),
        .round_result (round_result),
        .score0       (score0),
        .score1       (score1),
        .match_done   (match_done),
        .match_winner (match_winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Which player wins, by the game's "beats" relation rather than modular arithmetic.
    function automatic int ref_result(input int a, input int b);
        if (a == b) return 2;
        if (a == 3) return 1;
        if (b == 3) return 0;
        if ((a == 1 && b == 0) || (a == 2 && b == 1) || (a == 0 && b == 2)) return 0;
        return 1;
    endfunction

    task automatic model_start();
        m_s0 = 0; m_s1 = 0; m_ties = 0; m_done = 0; m_winner = 0;
    endtask

    task automatic model_round(input int r);
        if (r == 0) begin
            if (m_s0 < SCORE_MAX) m_s0++;
            m_ties = 0;
            if (m_s0 == WIN_TARGET) begin m_done = 1; m_winner = 0; end
        end else if (r == 1) begin
            if (m_s1 < SCORE_MAX) m_s1++;
            m_ties = 0;
            if (m_s1 == WIN_TARGET) begin m_done = 1; m_winner = 1; end
        end else begin
            m_ties++;
`ifdef RPS_TIE_LIMIT_EN
            if (m_ties == TIE_LIMIT) begin m_done = 1; m_winner = 2; end
`endif
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_start();
        check("start_score0", score0, 0);
        check("start_score1", score1, 0);
        check("start_ready", {p0_ready, p1_ready}, 2'b11);
        check("start_done", match_done, 0);
    endtask

    task automatic play_round(input int m0, input int m1, input int d0, input int d1);
        bit h0 = 0, h1 = 0, pend0 = 0, pend1 = 0, seen = 0;
        int viol = 0, lat_err = 0, cyc = 0, exp_r;
        exp_r = ref_result(m0, m1);
        while (!seen && cyc < 60) begin
            @(negedge clk);
            if (pend0) begin p0_valid = 1'b0; h0 = 1; pend0 = 0; end
            if (pend1) begin p1_valid = 1'b0; h1 = 1; pend1 = 0; end
            if (h0 && p0_ready) viol++;
            if (h1 && p1_ready) viol++;
            if (round_valid !== (h0 && h1)) lat_err++;
            if (round_valid === 1'b1) begin
                seen = 1;
                check("round_result", round_result, exp_r);
            end else begin
                if (!h0 && cyc >= d0) begin
                    p0_valid = 1'b1; p0_move = 2'(m0); pend0 = p0_ready;
                end
                if (!h1 && cyc >= d1) begin
                    p1_valid = 1'b1; p1_move = 2'(m1); pend1 = p1_ready;
                end
            end
            cyc++;
        end
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        check("round_seen", seen, 1);
        check("ready_low_while_held", viol, 0);
        check("round_latency", lat_err, 0);
        model_round(exp_r);
        @(negedge clk);
        check("score0", score0, m_s0);
        check("score1", score1, m_s1);
        check("match_done", match_done, m_done);
        if (m_done) begin
            check("match_winner", match_winner, m_winner);
            check("done_readies", {p0_ready, p1_ready}, 2'b00);
            pulse_start();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_cnt;
        rst = 1'b1; start = 1'b0;
        p0_valid = 1'b0; p1_valid = 1'b0; p0_move = 2'd0; p1_move = 2'd0;
        model_start();
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {p0_ready, p1_ready, round_valid, round_result, score0, score1, match_done, match_winner},
              0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_readies", {p0_ready, p1_ready}, 2'b00);
        pulse_start();

        // Three straight paper-over-rock rounds take the match.
        repeat (3) play_round(1, 0, 0, 0);

        // Player 1 commits early; player 0 arrives four cycles later.
        play_round(1, 2, 4, 0);

        // Every move pair, including illegal ones.
        pulse_start();
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                play_round(a, b, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));

        // Consecutive ties.
        pulse_start();
        repeat (5) play_round(2, 2, 0, 0);
        pulse_start();

        // start collides with a player 0 handshake mid-match.
        repeat (2) play_round(1, 0, 0, 0);
        @(negedge clk);
        p0_valid = 1'b1; p0_move = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; p0_valid = 1'b0;
        model_start();
        check("midstart_score0", score0, 0);
        check("midstart_score1", score1, 0);
        check("midstart_ready", {p0_ready, p1_ready}, 2'b11);
        check("midstart_no_round", round_valid, 0);
        rv_cnt = 0;
        p1_valid = 1'b1; p1_move = 2'd0;
        repeat (4) begin
            @(negedge clk);
            if (round_valid === 1'b1) rv_cnt++;
        end
        p1_valid = 1'b0;
        check("discarded_move", rv_cnt, 0);
        pulse_start();

        // Random play.
        for (int i = 0; i < 80; i++)
            play_round(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));

        // Asynchronous reset in the middle of RESOLVE.
        pulse_start();
        play_round(1, 0, 0, 0);
        @(negedge clk);
        p0_valid = 1'b1; p0_move = 2'd2; p1_valid = 1'b1; p1_move = 2'd1;
        @(negedge clk);
        p0_valid = 1'b0; p1_valid = 1'b0;
        check("pre_reset_resolve", {round_valid, score0}, {1'b1, 4'd1});
        #1 rst = 1'b1;
        #1;
        check("async_reset_outputs",
              {p0_ready, p1_ready, round_valid, round_result, score0, score1, match_done, match_winner},
              0);
        @(negedge clk);
        rst = 1'b0;
        model_start();
        @(negedge clk);
        check("post_reset_idle", {p0_ready, p1_ready, match_done}, 3'b000);
        pulse_start();
        play_round(0, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
